// File: rtl/x65_pkg.sv
// Shared definitions for the x65 CPU clocking slice: phaser state encodings and
// default PHI2 phase lengths.
package x65_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_HIGH    = 2'd1,
    ST_STRETCH = 2'd2,
    ST_STOPPED = 2'd3
  } phaser_state_t;

  localparam int unsigned PHI_LOW_CYC_DEF  = 3;
  localparam int unsigned PHI_HIGH_CYC_DEF = 3;
  localparam int unsigned STRETCH_CYC_DEF  = 6;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cpu_phaser_if.sv
// CPU phase/strobe bundle between cpu_phaser (master) and the bus controller (slave).
interface cpu_phaser_if #(
  parameter int unsigned CYC_CNT_W = 24
) ();
  logic                 run_cpu;
  logic                 stretch_req;
  logic                 cpu_phi2_o;
  logic                 setup_cs;
  logic                 release_cs;
  logic                 stopped_cpu;
  logic                 stretching_o;
  logic [CYC_CNT_W-1:0] cpu_cycles_o;

  modport master (
    input  run_cpu, stretch_req,
    output cpu_phi2_o, setup_cs, release_cs, stopped_cpu, stretching_o, cpu_cycles_o
  );

  modport slave (
    output run_cpu, stretch_req,
    input  cpu_phi2_o, setup_cs, release_cs, stopped_cpu, stretching_o, cpu_cycles_o
  );
endinterface

// File: rtl/cpu_phaser.sv
// CPU PHI2 generator with setup/release bus strobes and clean stop/restart.
// Optional PHI2-high stretching is built only when PHASER_STRETCH_EN is defined.
module cpu_phaser
  import x65_pkg::*;
#(
  parameter int unsigned PHI_LOW_CYC  = PHI_LOW_CYC_DEF,
  parameter int unsigned PHI_HIGH_CYC = PHI_HIGH_CYC_DEF,
  parameter int unsigned STRETCH_CYC  = STRETCH_CYC_DEF,
  parameter int unsigned CYC_CNT_W    = 24
) (
  input  logic         clk6x,
  input  logic         resetn,
  cpu_phaser_if.master bus
);

  localparam int unsigned PH_MAX = max3(PHI_LOW_CYC, PHI_HIGH_CYC, STRETCH_CYC);
  localparam int unsigned PH_W   = $clog2(PH_MAX);

  phaser_state_t        state_q, state_d;
  logic [PH_W-1:0]      cnt_q, cnt_d;
  logic                 phi2_q, phi2_d;
  logic                 setup_q, setup_d;
  logic                 release_q, release_d;
  logic                 stopped_q, stopped_d;
  logic                 stretching_q, stretching_d;
  logic [CYC_CNT_W-1:0] cyc_q, cyc_d;
`ifdef PHASER_STRETCH_EN
  logic                 lat_q, lat_d;
`else
  logic                 unused_stretch_req;
  assign unused_stretch_req = bus.stretch_req;
`endif

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_LOW;
      cnt_q        <= PH_W'(PHI_LOW_CYC - 1);
      phi2_q       <= 1'b0;
      setup_q      <= 1'b0;
      release_q    <= 1'b0;
      stopped_q    <= 1'b0;
      stretching_q <= 1'b0;
      cyc_q        <= '0;
`ifdef PHASER_STRETCH_EN
      lat_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phi2_q       <= phi2_d;
      setup_q      <= setup_d;
      release_q    <= release_d;
      stopped_q    <= stopped_d;
      stretching_q <= stretching_d;
      cyc_q        <= cyc_d;
`ifdef PHASER_STRETCH_EN
      lat_q        <= lat_d;
`endif
    end
  end

  // Outputs are registered from next-state values so every strobe lines up
  // exactly with the PHI2 phase it belongs to.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q - PH_W'(1);
    phi2_d       = 1'b0;
    setup_d      = 1'b0;
    release_d    = 1'b0;
    stopped_d    = 1'b0;
    stretching_d = 1'b0;
    cyc_d        = cyc_q;
`ifdef PHASER_STRETCH_EN
    lat_d        = lat_q;
`endif
    case (state_q)
      ST_LOW: begin
        if (cnt_q == '0) begin
          if (bus.run_cpu) begin
            state_d = ST_HIGH;
            cnt_d   = PH_W'(PHI_HIGH_CYC - 1);
            phi2_d  = 1'b1;
            setup_d = 1'b1;
          end else begin
            state_d   = ST_STOPPED;
            cnt_d     = cnt_q;
            stopped_d = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        phi2_d = 1'b1;
        if (cnt_q != '0) begin
`ifdef PHASER_STRETCH_EN
          lat_d     = lat_q | bus.stretch_req;
          release_d = (cnt_q == PH_W'(1)) && !lat_d;
`else
          release_d = (cnt_q == PH_W'(1));
`endif
        end else begin
`ifdef PHASER_STRETCH_EN
          lat_d = 1'b0;
          if (lat_q) begin
            state_d      = ST_STRETCH;
            cnt_d        = PH_W'(STRETCH_CYC - 1);
            stretching_d = 1'b1;
            release_d    = (STRETCH_CYC == 1);
          end else
`endif
          begin
            state_d = ST_LOW;
            cnt_d   = PH_W'(PHI_LOW_CYC - 1);
            phi2_d  = 1'b0;
            cyc_d   = cyc_q + CYC_CNT_W'(1);
          end
        end
      end

`ifdef PHASER_STRETCH_EN
      ST_STRETCH: begin
        phi2_d       = 1'b1;
        stretching_d = 1'b1;
        if (cnt_q != '0) begin
          release_d = (cnt_q == PH_W'(1));
        end else begin
          state_d      = ST_LOW;
          cnt_d        = PH_W'(PHI_LOW_CYC - 1);
          phi2_d       = 1'b0;
          stretching_d = 1'b0;
          cyc_d        = cyc_q + CYC_CNT_W'(1);
        end
      end
`endif

      ST_STOPPED: begin
        cnt_d     = cnt_q;
        stopped_d = 1'b1;
        // The low phase before parking already met PHI_LOW_CYC, so restart goes straight high.
        if (bus.run_cpu) begin
          state_d   = ST_HIGH;
          cnt_d     = PH_W'(PHI_HIGH_CYC - 1);
          phi2_d    = 1'b1;
          setup_d   = 1'b1;
          stopped_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_LOW;
        cnt_d   = PH_W'(PHI_LOW_CYC - 1);
      end
    endcase
  end

  assign bus.cpu_phi2_o   = phi2_q;
  assign bus.setup_cs     = setup_q;
  assign bus.release_cs   = release_q;
  assign bus.stopped_cpu  = stopped_q;
  assign bus.stretching_o = stretching_q;
  assign bus.cpu_cycles_o = cyc_q;

endmodule

// File: tb/tb_cpu_phaser.sv
// Directed bench for cpu_phaser: reset, free run, counter wrap (4-bit copy),
// stretch (PHASER_STRETCH_EN aware), stop/restart and asynchronous reset.
module tb_cpu_phaser;

`ifdef PHASER_STRETCH_EN
  localparam int EXP_HI  = 9;
  localparam int EXP_STR = 6;
`else
  localparam int EXP_HI  = 3;
  localparam int EXP_STR = 0;
`endif

  logic clk6x;
  logic resetn;
  logic run_cpu;
  logic stretch_req;

  int checks = 0;
  int errors = 0;

  cpu_phaser_if #(.CYC_CNT_W(24)) bus ();
  cpu_phaser_if #(.CYC_CNT_W(4))  bus_w ();

  assign bus.run_cpu       = run_cpu;
  assign bus.stretch_req   = stretch_req;
  assign bus_w.run_cpu     = run_cpu;
  assign bus_w.stretch_req = stretch_req;

  cpu_phaser #(.CYC_CNT_W(24)) dut (
    .clk6x  (clk6x),
    .resetn (resetn),
    .bus    (bus)
  );

  cpu_phaser #(.CYC_CNT_W(4)) dut_w (
    .clk6x  (clk6x),
    .resetn (resetn),
    .bus    (bus_w)
  );

  initial clk6x = 1'b0;
  always #5 clk6x = ~clk6x;

  task automatic tick();
    @(posedge clk6x);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walks one PHI2-high phase from its first cycle; optionally pulses stretch_req in that cycle.
  task automatic measure_high(input bit pulse, output int hi, output int nstr,
                              output int nrel, output int relpos);
    hi = 0; nstr = 0; nrel = 0; relpos = 0;
    for (int i = 0; i < 30 && bus.cpu_phi2_o === 1'b1; i++) begin
      hi++;
      if (bus.stretching_o === 1'b1) nstr++;
      if (bus.release_cs === 1'b1) begin
        nrel++;
        relpos = hi;
      end
      if (i == 0 && pulse) stretch_req = 1'b1;
      tick();
      stretch_req = 1'b0;
    end
  endtask

  task automatic measure_low(output int lo);
    lo = 0;
    for (int i = 0; i < 30 && bus.cpu_phi2_o === 1'b0; i++) begin
      lo++;
      tick();
    end
  endtask

  task automatic wait_setup();
    int n;
    n = 0;
    while (bus.setup_cs !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wait_setup_timeout", {31'd0, bus.setup_cs}, 32'd1);
  endtask

  initial begin
    int hi, nstr, nrel, relpos, lo;
    logic [2:0] pat, exp_pat;
    bit bad;

    resetn      = 1'b0;
    run_cpu     = 1'b1;
    stretch_req = 1'b0;
    #20;
    chk("rst_phi2",    {31'd0, bus.cpu_phi2_o},   32'd0);
    chk("rst_setup",   {31'd0, bus.setup_cs},     32'd0);
    chk("rst_release", {31'd0, bus.release_cs},   32'd0);
    chk("rst_stopped", {31'd0, bus.stopped_cpu},  32'd0);
    chk("rst_stretch", {31'd0, bus.stretching_o}, 32'd0);
    chk("rst_cycles",  32'(bus.cpu_cycles_o),     32'd0);

    tick();
    resetn = 1'b1;
    tick();
    chk("boot_setup_e1", {31'd0, bus.setup_cs}, 32'd0);
    tick();
    chk("boot_setup_e2", {31'd0, bus.setup_cs}, 32'd0);
    tick();
    chk("boot_setup_e3", {31'd0, bus.setup_cs},   32'd1);
    chk("boot_phi2_e3",  {31'd0, bus.cpu_phi2_o}, 32'd1);

    // 10 free-running periods: {phi2, setup, release} per cycle
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < 6; k++) begin
        pat = {bus.cpu_phi2_o, bus.setup_cs, bus.release_cs};
        case (k)
          0:       exp_pat = 3'b110;
          1:       exp_pat = 3'b100;
          2:       exp_pat = 3'b101;
          default: exp_pat = 3'b000;
        endcase
        chk($sformatf("run_p%0d_k%0d", p, k), {29'd0, pat}, {29'd0, exp_pat});
        tick();
      end
    end
    chk("cycles_10",   32'(bus.cpu_cycles_o),   32'd10);
    chk("cycles_w_10", 32'(bus_w.cpu_cycles_o), 32'd10);

    repeat (30) tick();
    chk("cycles_w_15", 32'(bus_w.cpu_cycles_o), 32'd15);
    repeat (6) tick();
    chk("cycles_w_wrap", 32'(bus_w.cpu_cycles_o), 32'd0);
    chk("cycles_16",     32'(bus.cpu_cycles_o),   32'd16);

    chk("str_start_setup", {31'd0, bus.setup_cs}, 32'd1);
    measure_high(1'b1, hi, nstr, nrel, relpos);
    chk("str_high_len",   32'(hi),     32'(EXP_HI));
    chk("str_stretching", 32'(nstr),   32'(EXP_STR));
    chk("str_nrel",       32'(nrel),   32'd1);
    chk("str_relpos",     32'(relpos), 32'(EXP_HI));
    measure_low(lo);
    chk("str_low_len", 32'(lo), 32'd3);
    measure_high(1'b0, hi, nstr, nrel, relpos);
    chk("post_high_len",   32'(hi),     32'd3);
    chk("post_stretching", 32'(nstr),   32'd0);
    chk("post_relpos",     32'(relpos), 32'd3);
    chk("cycles_18",       32'(bus.cpu_cycles_o), 32'd18);

    // Stop request on the 2nd high cycle
    wait_setup();
    tick();
    run_cpu = 1'b0;
    tick();
    chk("stop_release", {31'd0, bus.release_cs}, 32'd1);
    chk("stop_phi2_hi", {31'd0, bus.cpu_phi2_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stop_low%0d", k), {30'd0, bus.cpu_phi2_o, bus.stopped_cpu}, 32'd0);
    end
    tick();
    chk("stopped",      {31'd0, bus.stopped_cpu}, 32'd1);
    chk("stopped_phi2", {31'd0, bus.cpu_phi2_o},  32'd0);
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (bus.setup_cs !== 1'b0 || bus.cpu_phi2_o !== 1'b0 || bus.stopped_cpu !== 1'b1) bad = 1'b1;
    end
    chk("stopped_hold", {31'd0, bad}, 32'd0);

    run_cpu = 1'b1;
    tick();
    chk("restart_phi2",    {31'd0, bus.cpu_phi2_o},  32'd1);
    chk("restart_setup",   {31'd0, bus.setup_cs},    32'd1);
    chk("restart_stopped", {31'd0, bus.stopped_cpu}, 32'd0);

    // Asynchronous reset in the middle of a high phase
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_phi2",    {31'd0, bus.cpu_phi2_o}, 32'd0);
    chk("areset_strobes", {30'd0, bus.setup_cs, bus.release_cs}, 32'd0);
    chk("areset_cycles",  32'(bus.cpu_cycles_o), 32'd0);
    tick();
    resetn = 1'b1;
    bad = 1'b0;
    tick();
    if (bus.setup_cs !== 1'b0 || bus.release_cs !== 1'b0) bad = 1'b1;
    tick();
    if (bus.setup_cs !== 1'b0 || bus.release_cs !== 1'b0) bad = 1'b1;
    chk("rerun_quiet", {31'd0, bad}, 32'd0);
    tick();
    chk("rerun_setup", {31'd0, bus.setup_cs},   32'd1);
    chk("rerun_phi2",  {31'd0, bus.cpu_phi2_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_phaser.md
# cpu_phaser

- Generates the CPU PHI2 clock from clk6x (48 MHz).
- Emits the one-cycle `setup_cs` / `release_cs` strobes that frame every CPU bus cycle for the bus controller.
- Stops and restarts the CPU cleanly on `run_cpu` / `stopped_cpu` so a NORA master can take the bus.
- Sits directly upstream of the bus controller and drives the CPU PHI2 pin.

## Interface
Parameters:
- PHI_LOW_CYC, 3, clk6x cycles of PHI2 low per CPU cycle (min 2).
- PHI_HIGH_CYC, 3, clk6x cycles of PHI2 high per unstretched CPU cycle (min 2).
- STRETCH_CYC, 6, extra PHI2-high cycles added when stretching (min 1).
- CYC_CNT_W, 24, width of CPU cycle counter.

Ports:
- clk6x  in  1  48 MHz system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- run_cpu  in  1  1 = CPU may run; 0 = stop at next safe point.
- stretch_req  in  1  extend current PHI2-high phase (slow device, e.g. VIA).
- cpu_phi2_o  out  1  PHI2 to CPU pin, registered.
- setup_cs  out  1  one-cycle pulse; PHI2 rising, address valid.
- release_cs  out  1  one-cycle pulse; last clk6x cycle of PHI2 high, write data valid.
- stopped_cpu  out  1  1 = PHI2 parked low, CPU halted.
- stretching_o  out  1  1 while in stretch extension.
- cpu_cycles_o  out  CYC_CNT_W  count of completed CPU cycles, wraps.

## Operation
- States: ST_LOW, ST_HIGH, ST_STRETCH, ST_STOPPED. Down-counter `ph_cnt` is $clog2 of the largest phase length in width.
- Reset values:
  - state ST_LOW, ph_cnt = PHI_LOW_CYC-1.
  - cpu_phi2_o=0, setup_cs=0, release_cs=0, stopped_cpu=0, stretching_o=0, cpu_cycles_o=0.
- ST_LOW:
  - PHI2=0; decrement ph_cnt each cycle.
  - At ph_cnt==0 with run_cpu=1: go to ST_HIGH, load PHI_HIGH_CYC-1, assert cpu_phi2_o and setup_cs.
  - At ph_cnt==0 with run_cpu=0: go to ST_STOPPED, assert stopped_cpu.
- ST_HIGH:
  - PHI2=1; decrement ph_cnt.
  - release_cs is asserted when ph_cnt==1, i.e. registered so the pulse occupies the final high cycle.
  - At ph_cnt==0: go to ST_LOW, load PHI_LOW_CYC-1, PHI2=0, cpu_cycles_o+1.
  - A stretch latched during the phase instead moves to ST_STRETCH at ph_cnt==0; release_cs is then withheld.
- stretch_req is sampled every ST_HIGH cycle except the last. Any 1 latches the stretch for this CPU cycle only.
- ST_STRETCH:
  - PHI2=1, stretching_o=1, length STRETCH_CYC.
  - release_cs is in the final cycle.
  - Then go to ST_LOW and increment the counter.
- ST_STOPPED:
  - PHI2=0, stopped_cpu=1.
  - When run_cpu=1: next edge goes to ST_HIGH with setup_cs, and stopped_cpu drops on the same edge. The low phase already lasted at least PHI_LOW_CYC.
- Deasserting run_cpu during ST_HIGH/ST_STRETCH never truncates the cycle. The stop takes effect at the end of the following low phase.
- cpu_cycles_o wraps from all-ones to 0.

## Timing
- Default unstretched period is 6 clk6x (8 MHz PHI2), 50 % duty.
- setup_cs coincides with the first PHI2-high cycle; release_cs with the last. They are never in the same cycle.
- Stop latency: run_cpu falling, then stopped_cpu=1 at most PHI_HIGH_CYC+STRETCH_CYC+PHI_LOW_CYC+1 cycles later.
- Restart latency: run_cpu=1 sampled, then setup_cs/PHI2 rise on the next edge.
- Reset mid-phase (asynchronous): PHI2 drops immediately. No release_cs is produced for the aborted cycle.

## Configuration
- PHASER_STRETCH_EN defined: stretch_req, ST_STRETCH and stretching_o are functional.
- Undefined: stretch_req is ignored, ST_STRETCH is not generated, and stretching_o is tied 0. Every high phase is exactly PHI_HIGH_CYC.

## Structure
- Shared package x65_pkg holds:
  - the state encodings (2-bit ST_*);
  - default phase constants PHI_LOW_CYC_DEF=3, PHI_HIGH_CYC_DEF=3, STRETCH_CYC_DEF=6.
- Single module; no sub-module. The cycle counter is a plain register inside.

## Test plan
- Free run, run_cpu=1, defaults: PHI2 period 6, high for 3 cycles. setup_cs at the high-phase start and release_cs 2 cycles later. cpu_cycles_o=10 after 10 periods.
- run_cpu dropped on the 2nd high cycle: the current cycle completes with release_cs. The 3-cycle low follows, then stopped_cpu=1 with PHI2 held 0. No further setup_cs while stopped.
- From ST_STOPPED, raise run_cpu: next edge PHI2=1 and setup_cs=1, stopped_cpu=0.
- stretch_req pulsed 1 cycle in the 1st high cycle (macro defined): high phase lasts 9 cycles, stretching_o=1 for 6, release_cs on the 9th. Next cycle is normal (6). With macro undefined, the high phase stays 3.
- Assert resetn=0 mid-high-phase: PHI2 and all strobes go 0 at once and the counter clears. After release, the first setup_cs appears 3 cycles later.
- CYC_CNT_W=4: after 16 periods cpu_cycles_o wraps to 0.
